// File: rtl/sync_debounce.sv
// sync_debounce: per-channel multi-flop synchroniser followed by a
// stability filter with registered rising/falling edge pulses.
module sync_debounce #(
    parameter int WIDTH    = 3,
    parameter int STAGES   = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    input  logic             filt_en,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sync_debounce: WIDTH must be in 1..32");
    end
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("sync_debounce: STAGES must be in 2..4");
    end
    if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_debounce
        $error("sync_debounce: DEBOUNCE must be in 1..255");
    end

    logic [WIDTH-1:0] chain [STAGES];
    logic [CW-1:0]    cnt   [WIDTH];

    assign sync_out = chain[STAGES-1];

    // Synchroniser chain: only the first stage ever looks at async_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                chain[s] <= '0;
            end
        end else begin
            chain[0] <= async_in;
            for (int s = 1; s < STAGES; s++) begin
                chain[s] <= chain[s-1];
            end
        end
    end

    // Per-channel stability counter, filtered level and edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_out <= '0;
            rise     <= '0;
            fall     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!filt_en) begin
                    // Bypass: follow the synchronised level, drop any count.
                    cnt[i]      <= '0;
                    filt_out[i] <= sync_out[i];
                    rise[i]     <= sync_out[i] & ~filt_out[i];
                    fall[i]     <= ~sync_out[i] & filt_out[i];
                end else if (sync_out[i] == filt_out[i]) begin
                    cnt[i]  <= '0;
                    rise[i] <= 1'b0;
                    fall[i] <= 1'b0;
                end else if (cnt[i] == LAST) begin
                    // New level has been stable long enough: accept it.
                    cnt[i]      <= '0;
                    filt_out[i] <= sync_out[i];
                    rise[i]     <= sync_out[i];
                    fall[i]     <= ~sync_out[i];
                end else begin
                    cnt[i]  <= cnt[i] + CW'(1);
                    rise[i] <= 1'b0;
                    fall[i] <= 1'b0;
                end
            end
        end
    end

endmodule
